// File: rtl/rnd_pkg.sv
// Shared definitions for the random-number arbiter and its 13-bit Fibonacci LFSR.
package rnd_pkg;

  localparam int LFSR_W = 13;
  localparam logic [LFSR_W-1:0] LFSR_ZERO_SUB = 13'h1FFF;
  // Feedback taps at bit positions 12, 3, 2 and 0
  localparam logic [LFSR_W-1:0] LFSR_TAPS = 13'h100D;

  typedef enum logic [1:0] {
    ST_MIXING,
    ST_READY,
    ST_GRANT
  } arb_state_t;

  function automatic logic [LFSR_W-1:0] lfsr_next(input logic [LFSR_W-1:0] s);
    return {s[LFSR_W-2:0], ^(s & LFSR_TAPS)};
  endfunction

  function automatic logic [LFSR_W-1:0] seed_fix(input logic [LFSR_W-1:0] s);
    return (s == '0) ? LFSR_ZERO_SUB : s;
  endfunction

endpackage

// File: rtl/rnd_arbiter_if.sv
// Requester-side bus of the random arbiter: seeding, request/ack and delivered value.
interface rnd_arbiter_if #(
  parameter int N_REQ = 4
);
  import rnd_pkg::*;

  logic [LFSR_W-1:0] seed;
  logic              seed_load;
  logic [N_REQ-1:0]  req;
  logic [N_REQ-1:0]  ack;
  logic [LFSR_W-1:0] rnd_out;
  logic              busy;

  modport master (
    output seed, seed_load, req,
    input  ack, rnd_out, busy
  );

  modport slave (
    input  seed, seed_load, req,
    output ack, rnd_out, busy
  );

endinterface

// File: rtl/lfsr13_core.sv
// Free-running 13-bit Fibonacci LFSR; a zero load value is replaced so the lock-up state never occurs.
module lfsr13_core
  import rnd_pkg::*;
(
  input  logic              clock,
  input  logic              reset,
  input  logic              load,
  input  logic [LFSR_W-1:0] load_val,
  output logic [LFSR_W-1:0] state
);

  logic [LFSR_W-1:0] state_q;
  logic [LFSR_W-1:0] state_d;

  always_comb begin
    state_d = lfsr_next(state_q);
    if (reset || load) begin
      state_d = seed_fix(load_val);
    end
  end

  always_ff @(posedge clock) begin
    state_q <= state_d;
  end

  assign state = state_q;

endmodule

// File: rtl/rnd_arbiter.sv
// Round-robin arbiter sharing one LFSR among N_REQ requesters, with MIX_CYCLES shifts between deliveries.
module rnd_arbiter
  import rnd_pkg::*;
#(
  parameter int N_REQ      = 4,
  parameter int MIX_CYCLES = 13
) (
  input  logic         clock,
  input  logic         reset,
  rnd_arbiter_if.slave bus
);

  localparam int PTR_W = $clog2(N_REQ);
  localparam logic [3:0]       MIX_MAX  = 4'(MIX_CYCLES);
  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(N_REQ - 1);

  logic [LFSR_W-1:0] lfsr;
  logic [3:0]        mix_cnt_q, mix_cnt_d;
  logic [PTR_W-1:0]  ptr_q, ptr_d;
  logic [N_REQ-1:0]  ack_q, ack_d;
  logic [LFSR_W-1:0] rnd_q, rnd_d;
  logic [PTR_W-1:0]  grant_idx;
  logic [PTR_W-1:0]  ptr_inc;
  arb_state_t        state;

  lfsr13_core u_lfsr (
    .clock    (clock),
    .reset    (reset),
    .load     (bus.seed_load),
    .load_val (bus.seed),
    .state    (lfsr)
  );

  // State is a pure decode of the mix counter and the request vector.
  always_comb begin
    if (mix_cnt_q < MIX_MAX) begin
      state = ST_MIXING;
    end else if (bus.req == '0) begin
      state = ST_READY;
    end else begin
      state = ST_GRANT;
    end
  end

  // Scan offsets from far to near so the nearest set request above ptr wins.
  always_comb begin
    logic [PTR_W-1:0] idx;
    grant_idx = ptr_q;
    idx       = '0;
    for (int unsigned i = N_REQ; i > 0; i--) begin
      idx = PTR_W'((32'(ptr_q) + i - 1) % N_REQ);
      if (bus.req[idx]) begin
        grant_idx = idx;
      end
    end
  end

  assign ptr_inc = (grant_idx == PTR_LAST) ? '0 : grant_idx + 1'b1;

  always_comb begin
    mix_cnt_d = mix_cnt_q;
    ptr_d     = ptr_q;
    ack_d     = '0;
    rnd_d     = rnd_q;
    if (bus.seed_load) begin
      mix_cnt_d = '0;
    end else begin
      case (state)
        ST_MIXING: mix_cnt_d = mix_cnt_q + 4'd1;
        ST_READY:  mix_cnt_d = mix_cnt_q;
        ST_GRANT: begin
          ack_d[grant_idx] = 1'b1;
          rnd_d            = lfsr;
          ptr_d            = ptr_inc;
          mix_cnt_d        = '0;
        end
        default:   mix_cnt_d = '0;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      mix_cnt_q <= '0;
      ptr_q     <= '0;
      ack_q     <= '0;
      rnd_q     <= '0;
    end else begin
      mix_cnt_q <= mix_cnt_d;
      ptr_q     <= ptr_d;
      ack_q     <= ack_d;
      rnd_q     <= rnd_d;
    end
  end

  assign bus.ack     = ack_q;
  assign bus.rnd_out = rnd_q;
  assign bus.busy    = (state == ST_MIXING);

endmodule

// File: doc/rnd_arbiter.md
# rnd_arbiter

Shares one 13-bit Fibonacci LFSR random source among `N_REQ` game-logic requesters (spawners, item drops, AI moves). It grants pending requests round-robin. Between any two deliveries it enforces `MIX_CYCLES` shifts, so that no two requesters receive correlated values. It sits between the top-level seed source and every consumer of random numbers, replacing per-consumer LFSR instances.

## Interface
- `N_REQ`, default 4: number of requesters; legal range 2–8.
- `MIX_CYCLES`, default 13: shifts required between deliveries; legal range 1–15.
- `clock` in, 1 bit: rising-edge clock.
- `reset` in, 1 bit: synchronous, active-high.
- `seed` in, 13 bits: LFSR load value; sampled on `reset` or `seed_load`.
- `seed_load` in, 1 bit: one-cycle pulse that reseeds without a full reset.
- `req` in, `N_REQ` bits: level request per requester; held high until its `ack`.
- `ack` out, `N_REQ` bits: registered one-hot pulse, one cycle, marking the delivery.
- `rnd_out` out, 13 bits: registered value delivered with `ack`; holds until the next grant.
- `busy` out, 1 bit: high while `mix_cnt < MIX_CYCLES`, meaning no grant is possible this cycle.

## Operation
- **LFSR core**
  - Shifts left every cycle: `lfsr <= {lfsr[11:0], fb}`, where `fb = lfsr[12]^lfsr[3]^lfsr[2]^lfsr[0]`.
  - On `reset` or `seed_load`, loads `seed`. A seed of 0 is replaced by 13'h1FFF, so the all-zero state is unreachable.
- **Mix counter `mix_cnt`** (4 bits)
  - Cleared to 0 on reset, on `seed_load`, and on every grant.
  - Otherwise increments each cycle, saturating at `MIX_CYCLES`.
- **States**
  - MIXING: `mix_cnt < MIX_CYCLES`.
  - READY: `mix_cnt == MIX_CYCLES` and `req == 0`.
  - GRANT: `mix_cnt == MIX_CYCLES` and `req != 0`.
  - MIXING moves to READY or GRANT when the count reaches `MIX_CYCLES`. GRANT always returns to MIXING.
- **Grant**
  - Pick the first set `req` bit searching upward from `ptr`, wrapping modulo `N_REQ`.
  - At the edge, register `ack[g]=1` and `rnd_out=lfsr` (the current, pre-shift value).
  - Set `ptr <= (g+1) mod N_REQ` and `mix_cnt <= 0`.
- **Boundary conditions**
  - A `req` dropped before its `ack` is simply no longer considered. No value is lost or queued.
  - If `seed_load` and a grant condition occur in the same cycle, `seed_load` wins: no grant, the counter clears, and `ptr` is unchanged.
  - After reset: `ack=0`, `rnd_out=0`, `busy=1`, `ptr=0`, `mix_cnt=0`, `lfsr=seed` (or 1FFF if the seed is 0).
  - Reset asserted mid-mixing discards the pending delivery.

## Timing
- In the first cycle after `reset` deasserts, `lfsr=seed` and `mix_cnt=0`.
- The earliest grant decision is in cycle `MIX_CYCLES` after reset release. `ack` and `rnd_out` are visible one cycle later.
- Throughput is at most one grant per `MIX_CYCLES+1` cycles.
- Request-to-ack latency:
  - Minimum: 1 cycle (READY state).
  - Worst case for a steadily requesting line: `N_REQ*(MIX_CYCLES+1)` cycles.
- A requester whose `req` is still high in its `ack` cycle receives no second grant until the next READY window, and only if round-robin reaches it again.
- `busy` is combinational from `mix_cnt`. All other outputs are registered.

## Structure
- Shared package `rnd_pkg`:
  - `LFSR_W=13`
  - `LFSR_ZERO_SUB=13'h1FFF`
  - tap positions {12,3,2,0}
- Sub-module `lfsr13_core`:
  - Ports: `clock`, `reset`, `load`, `load_val`, `state`.
  - Free-running, with zero-seed substitution built in.
  - Replaces the ad-hoc LFSR instances in game logic.
- The arbiter holds the counter, the round-robin pointer and the output registers. Target size is about 150–200 lines total.

## Test plan
1. **Sequence and first delivery.** `seed=13'h0001`, reset, then hold `req=4'b0001`. Required LFSR sequence: 0001, 0003, 0007, 000E, 001C, 0038, 0071, 00E3, 01C7, 038E, 071C, 0E38, 1C71, 18E2. Required output: `ack=0001` with `rnd_out=13'h18E2` in cycle 14 after reset release.
2. **Round-robin.** `req=4'b1111` held continuously. Required `ack` order: 0001, 0010, 0100, 1000, 0001, spaced exactly 14 cycles apart. Each `ack` lasts one cycle.
3. **Zero seed.** `seed=0` and reset. Required: first state is 1FFF and the LFSR never reaches 0 over 8191 cycles. The period is checked equal to 8191.
4. **`seed_load` priority.** `req=0010` arrives at `mix_cnt=13` together with a `seed_load` pulse carrying `seed=13'h0001`. Required: no `ack` that cycle, and `ack=0010` with `rnd_out=18E2` 14 cycles later.
5. **Dropped request.** `req[2]` rises during MIXING and drops before READY. Required: no `ack[2]`, and `ptr` is unchanged.
6. **Reset mid-operation.** Assert reset with `mix_cnt=7` and `rnd_out` nonzero. Required: `ack=0`, `rnd_out=0`, `busy=1` in the cycle after, and test 1 behaviour repeats.
